// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the fetch/data SRAM bus arbiter: response tags,
// transfer sizes, grant and lock states.
package sram_bus_arbiter_pkg;

  localparam logic TAG_INST = 1'b0;
  localparam logic TAG_DATA = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } grant_e;

  typedef enum logic [1:0] {
    LK_IDLE = 2'd0,
    LK_INST = 2'd1,
    LK_DATA = 2'd2
  } lock_e;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order tag FIFO recording which master owns each outstanding slave
// transaction; the head is visible combinationally for response routing.
module arb_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_en;
  logic             w_pop_en;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_en = i_push & ~o_full;
  assign w_pop_en  = i_pop & ~o_empty;

  // Storage needs no reset: only entries between the pointers are ever read.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    always_ff @(posedge clk) begin
      if (w_push_en && (r_wr_ptr == AW'(gi))) begin
        r_mem[gi] <= i_push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Arbitrates the fetch and data masters onto one SRAM-like slave port with
// data priority, a fetch anti-starvation bound and in-order response routing.
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int MAX_OUTST    = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  output logic        err_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  lock_e       r_lock;
  lock_e       w_lock_next;
  grant_e      w_grant;
  logic [SW-1:0] r_starve;
  logic        r_err;
  logic        w_full;
  logic        w_empty;
  logic        w_head;
  logic        w_acc;

  // A lock only holds while its owner keeps requesting, so a cancelled
  // fetch releases the bus in the same cycle.
  always_comb begin
    w_grant = GNT_NONE;
    if (r_lock == LK_INST && inst_req) begin
      w_grant = GNT_INST;
    end else if (r_lock == LK_DATA && data_req) begin
      w_grant = GNT_DATA;
    end else if (w_full) begin
      w_grant = GNT_NONE;
    end else if (data_req && !(inst_req && r_starve == STARVE_MAX)) begin
      w_grant = GNT_DATA;
    end else if (inst_req) begin
      w_grant = GNT_INST;
    end
  end

  always_comb begin
    req   = 1'b0;
    wr    = 1'b0;
    size  = SIZE_B;
    addr  = '0;
    wdata = '0;
    case (w_grant)
      GNT_INST: begin
        req  = inst_req;
        size = SIZE_W;
        addr = inst_addr;
      end
      GNT_DATA: begin
        req   = data_req;
        wr    = data_wr;
        size  = data_size;
        addr  = data_addr;
        wdata = data_wdata;
      end
      default: ;
    endcase
  end

  assign w_acc        = req & addr_ok;
  assign inst_addr_ok = (w_grant == GNT_INST) & addr_ok & req & ~w_full;
  assign data_addr_ok = (w_grant == GNT_DATA) & addr_ok & req & ~w_full;

  always_comb begin
    w_lock_next = LK_IDLE;
    if (req && !addr_ok) begin
      w_lock_next = (w_grant == GNT_DATA) ? LK_DATA : LK_INST;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_lock <= LK_IDLE;
    else         r_lock <= w_lock_next;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_starve <= '0;
    end else if ((w_acc && w_grant == GNT_INST) || !inst_req) begin
      r_starve <= '0;
    end else if (w_acc && w_grant == GNT_DATA && r_starve != STARVE_MAX) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_err <= 1'b0;
    else         r_err <= r_err | (data_ok & w_empty);
  end

  arb_tag_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (1)
  ) u_tag_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .i_push      (w_acc),
    .i_push_data ((w_grant == GNT_DATA) ? TAG_DATA : TAG_INST),
    .i_pop       (data_ok),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head)
  );

  assign inst_data_ok = data_ok & ~w_empty & (w_head == TAG_INST);
  assign data_data_ok = data_ok & ~w_empty & (w_head == TAG_DATA);
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;
  assign err_o        = r_err;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter: a queue-based model checked every
// cycle, plus literal expectations for the scenarios of interest.
module tb_sram_bus_arbiter;

  localparam int MAX_OUTST    = 4;
  localparam int STARVE_LIMIT = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = 2'd0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        addr_ok = 1'b0, data_ok = 1'b0;
  logic [31:0] rdata = '0;
  logic        err_o;

  sram_bus_arbiter #(
    .MAX_OUTST    (MAX_OUTST),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .req          (req),
    .wr           (wr),
    .size         (size),
    .addr         (addr),
    .wdata        (wdata),
    .addr_ok      (addr_ok),
    .data_ok      (data_ok),
    .rdata        (rdata),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model state: queue of owner tags (0 inst, 1 data), starvation count,
  // lock owner (0 none, 1 inst, 2 data), sticky error.
  bit          check_en = 1'b0;
  bit          m_q[$];
  int          m_starve = 0;
  int          m_lock = 0;
  bit          m_err = 1'b0;
  int          m_g;
  bit          m_full, m_acc, m_iok, m_dok;
  logic [31:0] m_addr, m_wdata;
  logic        m_wr;
  logic [1:0]  m_size;

  always @(negedge clk) begin
    if (check_en) begin
      m_full = (m_q.size() == MAX_OUTST);
      m_g = 0;
      if (m_lock == 1 && inst_req)      m_g = 1;
      else if (m_lock == 2 && data_req) m_g = 2;
      else if (!m_full) begin
        if (data_req && !(inst_req && m_starve == STARVE_LIMIT)) m_g = 2;
        else if (inst_req) m_g = 1;
      end
      m_wr = 1'b0; m_size = 2'd0; m_addr = '0; m_wdata = '0;
      if (m_g == 1) begin m_size = 2'd2; m_addr = inst_addr; end
      if (m_g == 2) begin m_wr = data_wr; m_size = data_size; m_addr = data_addr; m_wdata = data_wdata; end
      m_acc = (m_g != 0) && addr_ok;
      m_iok = data_ok && m_q.size() > 0 && m_q[0] == 1'b0;
      m_dok = data_ok && m_q.size() > 0 && m_q[0] == 1'b1;

      chk("req", {31'd0, req}, {31'd0, m_g != 0});
      chk("wr", {31'd0, wr}, {31'd0, m_wr});
      chk("size", {30'd0, size}, {30'd0, m_size});
      chk("addr", addr, m_addr);
      chk("wdata", wdata, m_wdata);
      chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, m_g == 1 && addr_ok});
      chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, m_g == 2 && addr_ok});
      chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, m_iok});
      chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, m_dok});
      chk("inst_rdata", inst_rdata, rdata);
      chk("data_rdata", data_rdata, rdata);
      chk("err_o", {31'd0, err_o}, {31'd0, m_err});

      if (!resetn) begin
        m_q.delete(); m_starve = 0; m_lock = 0; m_err = 1'b0;
      end else begin
        if (data_ok) begin
          if (m_q.size() > 0) void'(m_q.pop_front());
          else m_err = 1'b1;
        end
        if (m_acc) m_q.push_back(m_g == 2);
        if ((m_acc && m_g == 1) || !inst_req) m_starve = 0;
        else if (m_acc && m_g == 2 && m_starve < STARVE_LIMIT) m_starve++;
        m_lock = ((m_g != 0) && !addr_ok) ? m_g : 0;
      end
    end
  end

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    inst_req = 0; inst_addr = '0; data_req = 0; data_wr = 0; data_size = 2'd0;
    data_addr = '0; data_wdata = '0; addr_ok = 0; data_ok = 0; rdata = '0;
  endtask

  string glog;

  initial begin
    idle();
    resetn = 0;
    nxt();
    check_en = 1'b1;
    nxt();
    resetn = 1;
    mid();
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    nxt();

    // Single fetch read
    inst_req = 1; inst_addr = 32'hBFC0_0000; addr_ok = 1;
    mid();
    chk("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    chk("t1_addr", addr, 32'hBFC0_0000);
    nxt();
    idle(); data_ok = 1; rdata = 32'h2408_0001;
    mid();
    chk("t1_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    chk("t1_inst_rdata", inst_rdata, 32'h2408_0001);
    chk("t1_data_data_ok", {31'd0, data_data_ok}, 32'd0);
    nxt();
    idle();

    // Both masters streaming, slave always ready
    glog = "";
    for (int k = 0; k < 8; k++) begin
      inst_req = 1; inst_addr = 32'hBFC0_0100 + 32'(k * 4);
      data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h8000_0000 + 32'(k * 4);
      addr_ok = 1; data_ok = (k > 0); rdata = 32'h1000 + 32'(k);
      mid();
      if (data_addr_ok) glog = {glog, "D"};
      else if (inst_addr_ok) glog = {glog, "I"};
      else glog = {glog, "-"};
      nxt();
    end
    n_vec++;
    if (glog != "DDDIDDDI") begin
      n_bad++;
      $display("FAIL grant_seq: got %s, expected DDDIDDDI", glog);
    end
    idle(); data_ok = 1; rdata = 32'h2000;
    mid();
    chk("t2_last_tag_inst", {31'd0, inst_data_ok}, 32'd1);
    nxt();
    idle();

    // Lock held on stalled fetch, then released by accept
    inst_req = 1; inst_addr = 32'hBFC0_0200;
    mid();
    chk("t3_req", {31'd0, req}, 32'd1);
    nxt();
    for (int k = 0; k < 2; k++) begin
      data_req = 1; data_addr = 32'h8000_2000; data_size = 2'd2;
      mid();
      chk("t3_locked_addr", addr, 32'hBFC0_0200);
      chk("t3_no_data_ok", {31'd0, data_addr_ok}, 32'd0);
      nxt();
    end
    addr_ok = 1;
    mid();
    chk("t3_inst_acc", {31'd0, inst_addr_ok}, 32'd1);
    chk("t3_data_wait", {31'd0, data_addr_ok}, 32'd0);
    nxt();
    inst_req = 0;
    mid();
    chk("t3_data_acc", {31'd0, data_addr_ok}, 32'd1);
    nxt();
    // Locked fetch cancelled: data granted in the same cycle
    inst_req = 1; inst_addr = 32'hBFC0_0300; data_req = 0; addr_ok = 0;
    mid();
    nxt();
    inst_req = 0; data_req = 1; addr_ok = 1;
    mid();
    chk("t3_cancel_addr", addr, 32'h8000_2000);
    chk("t3_cancel_acc", {31'd0, data_addr_ok}, 32'd1);
    nxt();
    idle(); data_ok = 1;
    mid(); chk("t3_rsp0_inst", {31'd0, inst_data_ok}, 32'd1); nxt();
    mid(); chk("t3_rsp1_data", {31'd0, data_data_ok}, 32'd1); nxt();
    mid(); chk("t3_rsp2_data", {31'd0, data_data_ok}, 32'd1); nxt();
    idle();

    // FIFO full behaviour
    for (int k = 0; k < 4; k++) begin
      data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h8000_3000 + 32'(k * 4);
      data_wdata = 32'(k); addr_ok = 1;
      mid();
      chk("t4_fill_acc", {31'd0, data_addr_ok}, 32'd1);
      nxt();
    end
    mid();
    chk("t4_full_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    chk("t4_full_req", {31'd0, req}, 32'd0);
    nxt();
    data_ok = 1;
    mid();
    chk("t4_pop_when_full", {31'd0, data_data_ok}, 32'd1);
    chk("t4_no_acc_when_full", {31'd0, data_addr_ok}, 32'd0);
    nxt();
    mid();
    chk("t4_push_pop_acc", {31'd0, data_addr_ok}, 32'd1);
    nxt();
    data_ok = 0;
    mid();
    chk("t4_refill_acc", {31'd0, data_addr_ok}, 32'd1);
    nxt();
    mid();
    chk("t4_full_again_req", {31'd0, req}, 32'd0);
    nxt();
    idle(); data_ok = 1;
    for (int k = 0; k < 4; k++) begin mid(); nxt(); end
    idle();

    // Interleaved I, D(byte write), I then three responses
    inst_req = 1; inst_addr = 32'hBFC0_0400; addr_ok = 1;
    mid(); nxt();
    inst_req = 0; data_req = 1; data_wr = 1; data_size = 2'd0;
    data_addr = 32'h8000_1003; data_wdata = 32'h0000_00AB;
    mid();
    chk("t5_wr", {31'd0, wr}, 32'd1);
    chk("t5_size", {30'd0, size}, 32'd0);
    chk("t5_addr", addr, 32'h8000_1003);
    chk("t5_wdata", wdata, 32'h0000_00AB);
    nxt();
    idle(); inst_req = 1; inst_addr = 32'hBFC0_0404; addr_ok = 1;
    mid(); nxt();
    idle(); data_ok = 1; rdata = 32'hA1;
    mid(); chk("t5_rsp0_inst", {31'd0, inst_data_ok}, 32'd1); nxt();
    rdata = 32'hA2;
    mid();
    chk("t5_rsp1_data", {31'd0, data_data_ok}, 32'd1);
    chk("t5_rsp1_not_inst", {31'd0, inst_data_ok}, 32'd0);
    nxt();
    rdata = 32'hA3;
    mid(); chk("t5_rsp2_inst", {31'd0, inst_data_ok}, 32'd1); nxt();
    idle();

    // Spurious response
    data_ok = 1; rdata = 32'hDEAD;
    mid();
    chk("t6_drop_inst", {31'd0, inst_data_ok}, 32'd0);
    chk("t6_drop_data", {31'd0, data_data_ok}, 32'd0);
    nxt();
    idle();
    for (int k = 0; k < 3; k++) begin
      mid(); chk("t6_err_sticky", {31'd0, err_o}, 32'd1); nxt();
    end
    resetn = 0;
    mid(); nxt();
    resetn = 1;
    mid();
    chk("t6_err_cleared", {31'd0, err_o}, 32'd0);
    nxt();

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
